regfile_wb_buffer: RTL and testbench

//  Write-back buffer that sits directly upstream of the register/regfile write port.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_wb_fifo.sv | 50 +++++
 rtl/regfile_wb_buffer.sv | 93 +++++++++
 tb/tb_regfile_wb_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and the write-back entry type.
package regfile_pkg;
  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_WIDTH-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_fifo.sv
// regfile_wb_fifo: circular FIFO with head/tail/count and an exposed storage view for lookup.
// Ports: clk_i, rst_ni (async active-low), clr_i (sync clear), push_i/pop_i, wdata_i,
//        full_o/empty_o/count_o status, head_o oldest-entry pointer, mem_o raw storage.
module regfile_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 wdata_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [$clog2(DEPTH)-1:0]     head_o,
  output logic [DEPTH-1:0][W-1:0]      mem_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0][W-1:0] mem_q;
  // Pointers are PW bits wide, so DEPTH being a power of two gives free modulo wrap.
  always_comb begin
    head_d  = clr_i ? '0 : head_q + PW'(pop_i);
    tail_d  = clr_i ? '0 : tail_q + PW'(push_i);
    count_d = clr_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[tail_q] <= wdata_i;
  end
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign head_o  = head_q;
  assign mem_o   = mem_q;
endmodule

// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: FIFO write-back buffer feeding a register-file write port, with pending-write lookup.
// Ports: clk_i, rst_ni (async active-low), flush_i; in_valid_i/in_ready_o/in_addr_i/in_data_i request side;
//        rf_busy_i stall, wr_enable_o/wr_addr_o/wr_data_o register-file side;
//        lookup_addr_i -> lookup_hit_o/lookup_data_o; count_o queued entries.
module regfile_wb_buffer
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DEPTH    = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ADDR_W-1:0]      in_addr_i,
  input  logic [WIDTH-1:0]       in_data_i,
  input  logic                   rf_busy_i,
  output logic                   wr_enable_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [WIDTH-1:0]       wr_data_o,
  input  logic [ADDR_W-1:0]      lookup_addr_i,
  output logic                   lookup_hit_o,
  output logic [WIDTH-1:0]       lookup_data_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + WIDTH;
  logic full, empty, push, pop, drop;
  logic [PW-1:0] head;
  logic [DEPTH-1:0][EW-1:0] mem;
  logic wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [PW-1:0] idx;
  assign drop       = ZERO_REG && in_addr_i == '0;
  assign in_ready_o = rst_ni && !full;
  // Flush still acknowledges the request but nothing reaches the queue.
  assign push = in_valid_i && in_ready_o && !drop && !flush_i;
  assign pop  = !empty && !rf_busy_i && !flush_i;
  regfile_wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_addr_i, in_data_i}),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o),
    .head_o  (head),
    .mem_o   (mem)
  );
  always_comb begin
    wr_en_d   = pop;
    wr_addr_d = pop ? mem[head][EW-1:WIDTH] : wr_addr_q;
    wr_data_d = pop ? mem[head][WIDTH-1:0] : wr_data_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign wr_enable_o = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  // Walk from oldest to youngest so later matches overwrite earlier ones; output stage is oldest of all.
  always_comb begin
    lookup_hit_o  = wr_en_q && wr_addr_q == lookup_addr_i;
    lookup_data_o = lookup_hit_o ? wr_data_q : '0;
    idx           = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count_o && mem[idx][EW-1:WIDTH] == lookup_addr_i) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = mem[idx][WIDTH-1:0];
      end
    end
    if (ZERO_REG && lookup_addr_i == '0) begin
      lookup_hit_o  = 1'b0;
      lookup_data_o = '0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_buffer.sv
// tb_regfile_wb_buffer: randomized and directed checks of regfile_wb_buffer against a queue model.
module tb_regfile_wb_buffer;
  import regfile_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, rf_busy, wr_enable, lookup_hit;
  logic [REG_ADDR_W-1:0] in_addr, wr_addr, lookup_addr;
  logic [REG_WIDTH-1:0] in_data, wr_data, lookup_data;
  logic [$clog2(DEPTH):0] count;
  int n_chk = 0;
  int n_fail = 0;
  wb_entry_t q[$];
  bit m_en;
  logic [REG_ADDR_W-1:0] m_addr;
  logic [REG_WIDTH-1:0] m_data;

  always #5 clk = ~clk;

  regfile_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr), .in_data_i(in_data),
    .rf_busy_i(rf_busy), .wr_enable_o(wr_enable), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .lookup_addr_i(lookup_addr), .lookup_hit_o(lookup_hit), .lookup_data_o(lookup_data),
    .count_o(count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input bit hard);
    q.delete();
    m_en = 0;
    if (hard) begin
      m_addr = '0;
      m_data = '0;
    end
  endtask

  task automatic compare();
    bit hit = 0;
    logic [REG_WIDTH-1:0] d = '0;
    if (lookup_addr != 0) begin
      for (int i = q.size() - 1; i >= 0 && !hit; i--)
        if (q[i].addr == lookup_addr) begin
          hit = 1;
          d = q[i].data;
        end
      if (!hit && m_en && m_addr == lookup_addr) begin
        hit = 1;
        d = m_data;
      end
    end
    chk("in_ready", in_ready, rst_n && q.size() < DEPTH);
    chk("count", count, q.size());
    chk("wr_enable", wr_enable, m_en);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    chk("lookup_hit", lookup_hit, hit);
    chk("lookup_data", lookup_data, d);
  endtask

  task automatic model_step();
    bit acc;
    if (!rst_n) return;
    if (flush) begin
      model_clear(0);
      return;
    end
    acc = in_valid && q.size() < DEPTH;
    m_en = q.size() > 0 && !rf_busy;
    if (m_en) begin
      m_addr = q[0].addr;
      m_data = q[0].data;
      void'(q.pop_front());
    end
    if (acc && in_addr != 0) q.push_back('{addr: in_addr, data: in_data});
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit v, input logic [REG_ADDR_W-1:0] a, input logic [REG_WIDTH-1:0] d);
    in_valid = v;
    in_addr = a;
    in_data = d;
  endtask

  initial begin
    rst_n = 1; flush = 0; rf_busy = 0; lookup_addr = 0;
    req(0, 0, 0);
    #2 rst_n = 0;
    model_clear(1);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_wen", wr_enable, 0);
    chk("rst_count", count, 0);
    tick();
    tick();
    rst_n = 1;
    #1 chk("rel_ready", in_ready, 1);
    // single write latency
    req(1, 3, 9876);
    tick();
    req(0, 0, 0);
    chk("t2_wen_n", wr_enable, 0);
    tick();
    chk("t2_wen", wr_enable, 1);
    chk("t2_addr", wr_addr, 3);
    chk("t2_data", wr_data, 9876);
    tick();
    chk("t2_wen_off", wr_enable, 0);
    chk("t2_count", count, 0);
    // fill under stall, then drain in order
    rf_busy = 1;
    for (int k = 1; k <= 4; k++) begin
      req(1, k[REG_ADDR_W-1:0], 100 + k);
      tick();
    end
    req(1, 5, 105);
    #1;
    chk("t3_count", count, 4);
    chk("t3_ready", in_ready, 0);
    tick();
    chk("t3_held", count, 4);
    rf_busy = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) req(0, 0, 0);
      chk("t3_wen", wr_enable, 1);
      chk("t3_order", wr_addr, k);
    end
    tick();
    // lookup priority
    rf_busy = 1;
    req(1, 7, 1);
    tick();
    req(1, 7, 2);
    tick();
    req(0, 0, 0);
    lookup_addr = 7;
    #1;
    chk("t4_hit", lookup_hit, 1);
    chk("t4_data", lookup_data, 2);
    rf_busy = 0;
    repeat (3) tick();
    chk("t4_nohit", lookup_hit, 0);
    chk("t4_nodata", lookup_data, 0);
    // zero-register drop and flush
    req(1, 0, 5);
    #1 chk("t5_zready", in_ready, 1);
    tick();
    req(0, 0, 0);
    chk("t5_zcount", count, 0);
    tick();
    chk("t5_zwen", wr_enable, 0);
    rf_busy = 1;
    for (int k = 0; k < 3; k++) begin
      req(1, 10 + k, 50 + k);
      tick();
    end
    req(1, 9, 99);
    flush = 1;
    #1 chk("t5_fready", in_ready, 1);
    tick();
    flush = 0;
    req(0, 0, 0);
    chk("t5_fcount", count, 0);
    chk("t5_fwen", wr_enable, 0);
    rf_busy = 0;
    tick();
    chk("t5_nowrite", wr_enable, 0);
    // async reset mid-drain
    rf_busy = 1;
    for (int k = 0; k < 3; k++) begin
      req(1, 20 + k, 70 + k);
      tick();
    end
    req(0, 0, 0);
    rf_busy = 0;
    tick();
    chk("t6_pre_wen", wr_enable, 1);
    chk("t6_pre_count", count, 2);
    rst_n = 0;
    model_clear(1);
    #1;
    chk("t6_wen", wr_enable, 0);
    chk("t6_count", count, 0);
    tick();
    rst_n = 1;
    repeat (3) begin
      tick();
      chk("t6_quiet", wr_enable, 0);
    end
    // randomized traffic
    repeat (2000) begin
      req($urandom_range(0, 99) < 60, REG_ADDR_W'($urandom_range(0, 7)), $urandom);
      rf_busy = $urandom_range(0, 99) < 45;
      flush = $urandom_range(0, 99) < 3;
      lookup_addr = REG_ADDR_W'($urandom_range(0, 7));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
